eth_frame_tx: RTL and testbench
===============================

# eth_frame_tx

Bit-serial Ethernet frame transmitter for the XVC microserver datapath, the transmit counterpart of the serial receive path that feeds `sgmii_rx_p/n`. Accepts a payload byte stream (destination MAC through end of data, no preamble or FCS) and puts one bit per clock on `sgmii_tx_p/n`: preamble, SFD, payload, zero pad to minimum length, and CRC-32 FCS, followed by an enforced interframe gap. Sits between the reply builder (ARP/XVC response) and the top-level pins in `entry_point`.

## Interface
- `MIN_LEN`, default 60: minimum payload bytes; shorter frames are padded with 0x00.
- `MAX_LEN`, default 1514: maximum payload bytes; longer frames are truncated.
- `IFG_BITS`, default 96: idle bit-times after each frame (≥1).
- `clk`  in  1  bit clock; one line bit per cycle.
- `reset_n`  in  1  asynchronous active-low reset.
- `tx_data`  in  8  payload byte.
- `tx_valid`  in  1  `tx_data`/`tx_last` valid.
- `tx_last`  in  1  marks the final payload byte.
- `tx_ready`  out  1  byte accepted when `tx_valid && tx_ready`.
- `sgmii_tx_p`  out  1  serial data, LSB of each byte first.
- `sgmii_tx_n`  out  1  always `~sgmii_tx_p`.
- `tx_active`  out  1  high from first preamble bit through last IFG cycle.
- `tx_done`  out  1  one-cycle pulse when a frame completes normally.
- `tx_err`  out  1  one-cycle pulse on underrun or truncation.

## Operation
- States: IDLE, PREAMBLE (56 bits of 0x55), SFD (0xD5), PAYLOAD, PAD, FCS (32 bits), IFG, DROP.
- Byte shift register plus a 3-bit bit counter. Each byte is sent LSB first. The next byte loads at bit 7.
- IDLE to PREAMBLE when `tx_valid`=1. No byte is consumed on this transition.
- `tx_ready`=1 only in the bit-7 cycle of SFD or PAYLOAD while `tx_last` has not yet been accepted, and in every DROP cycle.
- In SFD or PAYLOAD, at bit 7 with `tx_ready`=1:
  - Handshake occurs: load `tx_data` and go to (or stay in) PAYLOAD. Latch `tx_last`.
  - `tx_valid`=0 in PAYLOAD (underrun): pulse `tx_err`, go to DROP, line idle. In SFD, `tx_valid`=0 is also treated as underrun.
- After the last payload byte's bit 7:
  - Byte count < `MIN_LEN`: go to PAD and emit 0x00 bytes until the count reaches `MIN_LEN`.
  - Otherwise go to FCS.
- Byte count (11 bits, saturating) reaches `MAX_LEN` without `tx_last`: finish normally through FCS, pulse `tx_err` at the FCS entry, then enter DROP after IFG.
- CRC-32, reflected polynomial 0xEDB88320:
  - Initialise to 0xFFFFFFFF at SFD.
  - Update bit-serially on every PAYLOAD and PAD bit driven.
  - FCS = ~crc, sent bit 0 first.
- FCS to IFG: pulse `tx_done` in the first IFG cycle. Hold the line idle for `IFG_BITS` cycles, then go to IDLE.
- DROP:
  - Line idle, `tx_active`=0.
  - Discard bytes until `tx_last` is accepted, then go to IFG. No `tx_done`.
- Idle line is `sgmii_tx_p`=0, `sgmii_tx_n`=1.
- `reset_n` low at any time:
  - Abort immediately, state IDLE.
  - All outputs take reset values: `sgmii_tx_p`=0, `sgmii_tx_n`=1, `tx_ready`=0, `tx_active`=0, `tx_done`=0, `tx_err`=0.
  - No partial FCS or gap is sent.

## Timing
- Outputs are registered. The first preamble bit appears on the cycle after IDLE samples `tx_valid`=1.
- First payload byte is accepted in cycle 63 of the frame (SFD bit 7). Its bit 0 is driven in cycle 64.
- Frame length in cycles: 64 + 8·max(N, `MIN_LEN`) + 32. Then `IFG_BITS` idle cycles. The next frame starts no earlier than the cycle after the last IFG cycle.
- `tx_valid` may stay high through IFG. The new frame still starts only from IDLE.
- `tx_ready` is never high for two consecutive cycles outside DROP.

## Test plan
- Payload "123456789" (9 bytes), `MIN_LEN`=0 -> line carries 7×0x55, 0xD5, bytes 31..39 LSB-first, FCS bytes 26 39 F4 CB; `tx_done` at cycle 64+72+32; `tx_active` low 96 cycles later.
- 42-byte ARP reply, default `MIN_LEN` -> 18 bytes of 0x00 appended; FCS covers all 60 bytes (checked against a software CRC); total 576 cycles plus 96 IFG.
- Deassert `tx_valid` before byte 20 is due -> `tx_err` pulses in that bit-7 cycle; line idle; `tx_ready` stays high until `tx_last` is taken; no `tx_done`; IDLE after 96 cycles.
- 1600-byte stream, `tx_last` on byte 1600 -> exactly 1514 bytes transmitted, valid FCS, `tx_err` pulse, bytes 1515–1600 drained in DROP.
- Two back-to-back 60-byte frames with `tx_valid` held high -> exactly 96 idle cycles between FCS end and the second preamble.
- `reset_n` pulsed low mid-payload -> outputs at reset values asynchronously; the next `tx_valid` produces a clean full frame.

Source files
------------

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: bit-serial Ethernet frame transmitter.
// Sends preamble, SFD, payload, pad and CRC-32 FCS, then an interframe gap.
module eth_frame_tx #(
    parameter int MIN_LEN  = 60,
    parameter int MAX_LEN  = 1514,
    parameter int IFG_BITS = 96
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       sgmii_tx_p,
    output logic       sgmii_tx_n,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_PAY,
        S_PAD,
        S_FCS,
        S_IFG,
        S_DROP
    } state_t;

    localparam logic [31:0] POLY      = 32'hEDB88320;
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_BITS - 1);

    state_t      state;
    logic [2:0]  bcnt;
    logic [7:0]  sh;
    logic [10:0] cnt;
    logic [31:0] crc;
    logic [15:0] gap;
    logic        last_seen;
    logic        trunc;

    logic [2:0]  bcnt_inc;
    logic [10:0] cnt_inc;
    logic [31:0] crc_nxt;
    logic        byte_end;
    logic        more_ok;
    logic        rdy_arm;

    assign sgmii_tx_n = ~sgmii_tx_p;

    // Next-bit helpers: bit index, saturating byte count, serial CRC step.
    always_comb begin
        bcnt_inc = bcnt + 3'd1;
        cnt_inc  = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
        byte_end = (bcnt == 3'd7);
        more_ok  = !last_seen && (cnt < MAX_LEN_C);
        crc_nxt  = {1'b0, crc[31:1]} ^ ((crc[0] ^ sh[bcnt]) ? POLY : 32'h0);
        rdy_arm  = (bcnt == 3'd6) &&
                   ((state == S_SFD) || ((state == S_PAY) && more_ok));
    end

    // Frame sequencer; every output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bcnt       <= 3'd0;
            sh         <= 8'h00;
            cnt        <= 11'd0;
            crc        <= 32'hFFFFFFFF;
            gap        <= 16'd0;
            last_seen  <= 1'b0;
            trunc      <= 1'b0;
            sgmii_tx_p <= 1'b0;
            tx_ready   <= 1'b0;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            tx_ready <= rdy_arm;
            unique case (state)
                S_IDLE: begin
                    sgmii_tx_p <= 1'b0;
                    if (tx_valid) begin
                        state      <= S_PRE;
                        bcnt       <= 3'd0;
                        sh         <= 8'h55;
                        cnt        <= 11'd0;
                        last_seen  <= 1'b0;
                        trunc      <= 1'b0;
                        sgmii_tx_p <= 1'b1;
                        tx_active  <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (!byte_end) begin
                        bcnt       <= bcnt_inc;
                        sgmii_tx_p <= sh[bcnt_inc];
                    end else begin
                        bcnt       <= 3'd0;
                        sgmii_tx_p <= 1'b1;
                        if (cnt == 11'd6) begin
                            state <= S_SFD;
                            sh    <= 8'hD5;
                            cnt   <= 11'd0;
                            crc   <= 32'hFFFFFFFF;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_SFD, S_PAY: begin
                    if (state == S_PAY) begin
                        crc <= crc_nxt;
                    end
                    if (!byte_end) begin
                        bcnt       <= bcnt_inc;
                        sgmii_tx_p <= sh[bcnt_inc];
                    end else if (state == S_SFD || more_ok) begin
                        bcnt <= 3'd0;
                        if (tx_valid) begin
                            state      <= S_PAY;
                            sh         <= tx_data;
                            sgmii_tx_p <= tx_data[0];
                            cnt        <= cnt_inc;
                            last_seen  <= tx_last;
                        end else begin
                            state      <= S_DROP;
                            sgmii_tx_p <= 1'b0;
                            tx_active  <= 1'b0;
                            tx_ready   <= 1'b1;
                            tx_err     <= 1'b1;
                        end
                    end else if (cnt < MIN_LEN_C) begin
                        state      <= S_PAD;
                        bcnt       <= 3'd0;
                        sh         <= 8'h00;
                        sgmii_tx_p <= 1'b0;
                        cnt        <= cnt_inc;
                    end else begin
                        state      <= S_FCS;
                        crc        <= ~crc_nxt;
                        sgmii_tx_p <= ~crc_nxt[0];
                        cnt        <= 11'd0;
                        if (!last_seen) begin
                            tx_err <= 1'b1;
                            trunc  <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    crc <= crc_nxt;
                    if (!byte_end) begin
                        bcnt       <= bcnt_inc;
                        sgmii_tx_p <= 1'b0;
                    end else if (cnt < MIN_LEN_C) begin
                        bcnt       <= 3'd0;
                        sgmii_tx_p <= 1'b0;
                        cnt        <= cnt_inc;
                    end else begin
                        state      <= S_FCS;
                        crc        <= ~crc_nxt;
                        sgmii_tx_p <= ~crc_nxt[0];
                        cnt        <= 11'd0;
                    end
                end
                S_FCS: begin
                    if (cnt == 11'd31) begin
                        state      <= S_IFG;
                        gap        <= 16'd0;
                        sgmii_tx_p <= 1'b0;
                        tx_done    <= 1'b1;
                    end else begin
                        crc        <= {1'b0, crc[31:1]};
                        sgmii_tx_p <= crc[1];
                        cnt        <= cnt_inc;
                    end
                end
                S_IFG: begin
                    sgmii_tx_p <= 1'b0;
                    if (gap != IFG_LAST) begin
                        gap <= gap + 16'd1;
                    end else if (trunc) begin
                        state     <= S_DROP;
                        trunc     <= 1'b0;
                        tx_active <= 1'b0;
                        tx_ready  <= 1'b1;
                    end else if (tx_valid) begin
                        state      <= S_PRE;
                        bcnt       <= 3'd0;
                        sh         <= 8'h55;
                        cnt        <= 11'd0;
                        last_seen  <= 1'b0;
                        sgmii_tx_p <= 1'b1;
                        tx_active  <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        tx_active <= 1'b0;
                    end
                end
                S_DROP: begin
                    sgmii_tx_p <= 1'b0;
                    tx_ready   <= 1'b1;
                    if (tx_valid && tx_last) begin
                        state    <= S_IFG;
                        gap      <= 16'd0;
                        tx_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: scoreboard bench for eth_frame_tx.
// Frames are rebuilt byte-wise from payloads and compared bit by bit.
module tb_eth_frame_tx;

    localparam int MIN_LEN  = 60;
    localparam int MAX_LEN  = 1514;
    localparam int IFG_BITS = 96;

    localparam int M_WAIT = 0;
    localparam int M_CAP  = 1;
    localparam int M_GAP  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       sgmii_tx_p;
    logic       sgmii_tx_n;
    logic       tx_active;
    logic       tx_done;
    logic       tx_err;

    int checks = 0;
    int errors = 0;

    bit exp_bits[$];
    int exp_kind[$];
    int exp_nbits[$];
    int exp_errpos[$];

    int mode = M_WAIT;
    bit cap[$];
    int cap_errpos;
    int gapcnt;
    bit prev_rdy = 1'b0;

    eth_frame_tx #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .IFG_BITS(IFG_BITS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .sgmii_tx_p(sgmii_tx_p),
        .sgmii_tx_n(sgmii_tx_n),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input bit ok, input string name,
                                input int got, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    // Standard reflected CRC-32 over whole bytes, returns the FCS value.
    function automatic logic [31:0] crc32(input byte unsigned d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected line image for a payload; under_at >= 0 means the source
    // withholds that byte index.
    task automatic push_expect(input byte unsigned p[$], input int under_at);
        byte unsigned line[$];
        byte unsigned data[$];
        logic [31:0] fcs;
        int n;
        for (int i = 0; i < 7; i++) line.push_back(8'h55);
        line.push_back(8'hD5);
        if (under_at >= 0) begin
            for (int i = 0; i < under_at; i++) line.push_back(p[i]);
            exp_kind.push_back(1);
            exp_errpos.push_back(64 + 8 * under_at);
        end else begin
            n = (p.size() > MAX_LEN) ? MAX_LEN : p.size();
            for (int i = 0; i < n; i++) data.push_back(p[i]);
            while (data.size() < MIN_LEN) data.push_back(8'h00);
            fcs = crc32(data);
            foreach (data[i]) line.push_back(data[i]);
            for (int i = 0; i < 4; i++) line.push_back(fcs[8*i +: 8]);
            if (p.size() > MAX_LEN) begin
                exp_kind.push_back(2);
                exp_errpos.push_back(64 + 8 * MAX_LEN);
            end else begin
                exp_kind.push_back(0);
                exp_errpos.push_back(-1);
            end
        end
        exp_nbits.push_back(8 * line.size());
        foreach (line[i])
            for (int b = 0; b < 8; b++) exp_bits.push_back(line[i][b]);
    endtask

    task automatic finish_frame(input bit by_done);
        int kind, nb, ep, bad, first;
        bit e;
        if (exp_kind.size() == 0) begin
            chk(1'b0, "unexpected_frame", cap.size(), 0);
            return;
        end
        kind = exp_kind.pop_front();
        nb   = exp_nbits.pop_front();
        ep   = exp_errpos.pop_front();
        bad  = 0;
        first = -1;
        for (int i = 0; i < nb; i++) begin
            e = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'b0;
            if (i >= cap.size() || cap[i] != e) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk(by_done == (kind != 1), "frame_end_by_done", by_done, kind != 1);
        chk(cap.size() == nb, "frame_bits", cap.size(), nb);
        chk(bad == 0, "frame_content_first_bad_bit", first, -1);
        chk(cap_errpos == ep, "tx_err_position", cap_errpos, ep);
    endtask

    task automatic start_cap();
        cap.delete();
        cap.push_back(sgmii_tx_p);
        cap_errpos = tx_err ? 0 : -1;
        mode = M_CAP;
    endtask

    // Monitor: rebuilds each frame from the line and scores it.
    always @(negedge clk) begin
        if (!reset_n) begin
            if (mode == M_CAP) begin
                if (exp_kind.size() != 0) begin
                    chk(exp_kind[0] == 3, "abort_kind", exp_kind[0], 3);
                    void'(exp_kind.pop_front());
                    void'(exp_nbits.pop_front());
                    void'(exp_errpos.pop_front());
                end else begin
                    chk(1'b0, "abort_without_expect", 0, 1);
                end
            end
            mode = M_WAIT;
            prev_rdy = 1'b0;
        end else begin
            chk(sgmii_tx_n == ~sgmii_tx_p, "tx_n_inverse", sgmii_tx_n, ~sgmii_tx_p);
            if (tx_active && tx_ready)
                chk(!prev_rdy, "ready_two_cycles", 1, 0);
            prev_rdy = tx_active && tx_ready;
            case (mode)
                M_WAIT: begin
                    if (tx_done) chk(1'b0, "done_outside_frame", 1, 0);
                    if (tx_active && sgmii_tx_p) start_cap();
                end
                M_CAP: begin
                    if (tx_err && cap_errpos < 0) cap_errpos = cap.size();
                    if (tx_done || !tx_active) begin
                        finish_frame(tx_done);
                        mode = tx_done ? M_GAP : M_WAIT;
                        gapcnt = 1;
                    end else begin
                        if (tx_ready)
                            chk((cap.size() % 8 == 7) && (cap.size() >= 63),
                                "ready_bit_index", cap.size(), 63);
                        cap.push_back(sgmii_tx_p);
                    end
                end
                default: begin
                    if (!tx_active || sgmii_tx_p) begin
                        chk(gapcnt == IFG_BITS, "ifg_length", gapcnt, IFG_BITS);
                        mode = M_WAIT;
                        if (tx_active && sgmii_tx_p) start_cap();
                    end else begin
                        gapcnt++;
                    end
                end
            endcase
        end
    end

    // Source: offers bytes, optionally starves the DUT at byte under_at.
    task automatic drive(input byte unsigned p[$], input int under_at,
                         input bit keep_valid);
        int i, cyc;
        bit acc, ur, under_done;
        i = 0;
        cyc = 0;
        under_done = 1'b0;
        tx_data  = p[0];
        tx_last  = (p.size() == 1);
        tx_valid = 1'b1;
        while (i < p.size()) begin
            @(negedge clk);
            acc = tx_valid && tx_ready;
            ur  = !tx_valid && tx_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) i++;
            if (ur) under_done = 1'b1;
            if (i < p.size()) begin
                tx_data  = p[i];
                tx_last  = (i == p.size() - 1);
                tx_valid = !(i == under_at && !under_done);
            end
            if (cyc > 30000) begin
                chk(1'b0, "source_timeout", i, p.size());
                break;
            end
        end
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drained(input int limit);
        int c;
        c = 0;
        while ((exp_kind.size() != 0 || mode != M_WAIT || tx_active) && c < limit) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(c < limit, "drain_timeout", c, limit);
    endtask

    task automatic rand_payload(output byte unsigned p[$], input int n);
        p.delete();
        for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned p[$];
        byte unsigned q[$];
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(sgmii_tx_p == 1'b0, "reset_tx_p", sgmii_tx_p, 0);
        chk(sgmii_tx_n == 1'b1, "reset_tx_n", sgmii_tx_n, 1);
        chk(tx_ready == 1'b0, "reset_ready", tx_ready, 0);
        chk(tx_active == 1'b0, "reset_active", tx_active, 0);
        reset_n = 1'b1;
        idle(2);

        p.delete();
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
        chk(crc32(p) == 32'hCBF43926, "model_crc_check", 0, 1);
        push_expect(p, -1);
        drive(p, -1, 1'b0);
        idle(5);

        rand_payload(p, 42);
        push_expect(p, -1);
        drive(p, -1, 1'b0);
        idle(3);

        for (int k = 0; k < 3; k++) begin
            rand_payload(p, (k == 0) ? 1 : (k == 1) ? MIN_LEN : MIN_LEN + 1);
            push_expect(p, -1);
            drive(p, -1, 1'b0);
            idle($urandom_range(0, 30));
        end

        for (int f = 0; f < 6; f++) begin
            rand_payload(p, $urandom_range(1, 160));
            push_expect(p, -1);
            drive(p, -1, 1'b0);
            idle($urandom_range(0, 30));
        end
        wait_drained(3000);

        rand_payload(p, 40);
        push_expect(p, 19);
        drive(p, 19, 1'b0);
        wait_drained(3000);
        idle(IFG_BITS + 4);

        rand_payload(p, 1600);
        push_expect(p, -1);
        drive(p, -1, 1'b0);
        wait_drained(3000);
        idle(IFG_BITS + 4);

        rand_payload(p, MIN_LEN);
        rand_payload(q, MIN_LEN);
        push_expect(p, -1);
        drive(p, -1, 1'b1);
        push_expect(q, -1);
        drive(q, -1, 1'b0);
        wait_drained(3000);

        exp_kind.push_back(3);
        exp_nbits.push_back(0);
        exp_errpos.push_back(-1);
        tx_data  = 8'hA5;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        repeat (110) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk(sgmii_tx_p == 1'b0, "async_reset_tx_p", sgmii_tx_p, 0);
        chk(sgmii_tx_n == 1'b1, "async_reset_tx_n", sgmii_tx_n, 1);
        chk(tx_ready == 1'b0, "async_reset_ready", tx_ready, 0);
        chk(tx_active == 1'b0, "async_reset_active", tx_active, 0);
        chk(tx_done == 1'b0, "async_reset_done", tx_done, 0);
        chk(tx_err == 1'b0, "async_reset_err", tx_err, 0);
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        idle(2);

        rand_payload(p, 50);
        push_expect(p, -1);
        drive(p, -1, 1'b0);
        wait_drained(3000);
        chk(exp_kind.size() == 0, "scoreboard_empty", exp_kind.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
